// File: rtl/serial_loader_pkg.sv
// Shared definitions for the serial_loader block: FSM state encoding and
// the bit-counter width helper. PAR is kept in the enum in every build so
// the encoding does not change with PARITY_CHK_EN.
package serial_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        LOAD  = 2'd3
    } state_t;

    // Width needed to hold a count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_loader_bit_counter.sv
// bit_counter: N-terminal up-counter. Counts accepted bits, raises done while
// the count sits at N-1 (the next increment completes a word) and wraps to 0
// on that increment. clr discards the current count.
module bit_counter
    import serial_loader_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam int W = cnt_width(N);

    logic [W-1:0] cnt;

    // Count register: reset/clear to zero, wrap after the Nth increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

    assign done = (cnt == W'(N - 1));

endmodule

// File: rtl/serial_loader.sv
// serial_loader: collects N serial bits over a valid/ready handshake and
// presents the completed word on par_out together with a one-cycle load
// pulse for a downstream parallel register (which samples on the falling
// edge; everything here changes on the rising edge only).
// Optional feature macro: PARITY_CHK_EN adds a trailing parity bit per word,
// checked with sense PARITY_ODD; failures pulse par_err and drop the word.
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter int N          = 4,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_valid,
    output logic         sin_ready,
    input  logic         clear,
    output logic [N-1:0] par_out,
    output logic         load,
    output logic         busy,
    output logic         par_err
);

    if (N < 2 || MSB_FIRST < 0 || MSB_FIRST > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("serial_loader: N must be >= 2, MSB_FIRST and PARITY_ODD must be 0 or 1");
    end

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] shift;
    logic [N-1:0] shift_nxt;
    logic         take;
    logic         data_take;
    logic         last_bit;
    logic         commit;
    logic [N-1:0] word;

    // A bit only counts when the handshake completes and no abort is pending.
    assign take      = sin_valid && sin_ready && !clear;
    assign data_take = take && (state == IDLE || state == SHIFT);
    assign shift_nxt = (MSB_FIRST != 0) ? {shift[N-2:0], sin} : {sin, shift[N-1:1]};

    bit_counter #(.N(N)) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (data_take),
        .done (last_bit)
    );

`ifdef PARITY_CHK_EN
    logic par_ok;

    // Ones over data plus parity bit must match the configured sense.
    assign par_ok = (((^shift) ^ sin) == (PARITY_ODD != 0));
    assign commit = take && (state == PAR) && par_ok;
    assign word   = shift;

    // Parity failure flag: one-cycle pulse after the rejected parity bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= take && (state == PAR) && !par_ok;
        end
    end
`else
    assign commit  = data_take && (state == SHIFT) && last_bit;
    assign word    = shift_nxt;
    assign par_err = 1'b0;
`endif

    // Shift register assembling the word in progress.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift <= '0;
        end else if (data_take) begin
            shift <= shift_nxt;
        end
    end

    // Output word: only updated on the edge that enters LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_out <= '0;
        end else if (commit) begin
            par_out <= word;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; clear aborts any partial word.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (clear) begin
                    state_nxt = IDLE;
                end else if (take && last_bit) begin
`ifdef PARITY_CHK_EN
                    state_nxt = PAR;
`else
                    state_nxt = LOAD;
`endif
                end
            end
`ifdef PARITY_CHK_EN
            PAR: begin
                if (clear) begin
                    state_nxt = IDLE;
                end else if (take) begin
                    state_nxt = par_ok ? LOAD : IDLE;
                end
            end
`endif
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: LOAD is a one-cycle bubble that refuses input.
    always_comb begin
        load      = (state == LOAD);
        busy      = (state != IDLE);
        sin_ready = !rst && (state != LOAD);
    end

endmodule

// File: tb/tb_serial_loader.sv
// Bench for serial_loader: two instances (LSB-first and MSB-first) share one
// stimulus stream. Directed table rows carry hand-derived expectations; a
// queue-based reference model checks every cycle, including a random phase.
module tb_serial_loader;

    localparam int N = 4;
`ifdef PARITY_CHK_EN
    localparam int NB = N + 1;
`else
    localparam int NB = N;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         clear = 1'b0;
    logic         rdy0, load0, busy0, err0;
    logic         rdy1, load1, busy1, err1;
    logic [N-1:0] po0, po1;

    serial_loader #(.N(N), .MSB_FIRST(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_ready(rdy0),
        .clear(clear), .par_out(po0), .load(load0), .busy(busy0), .par_err(err0)
    );

    serial_loader #(.N(N), .MSB_FIRST(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_ready(rdy1),
        .clear(clear), .par_out(po1), .load(load1), .busy(busy1), .par_err(err1)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cycle   = 0;

    // Reference model: bits collected so far, plus the per-cycle flags.
    bit           q[$];
    bit           m_loading = 1'b0;
    bit           m_err     = 1'b0;
    bit           m_rst     = 1'b1;
    logic [N-1:0] m_po0 = '0;
    logic [N-1:0] m_po1 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    endtask

    task automatic model_step(input bit r, input bit c, input bit v, input bit s);
        bit nl, ne, ok;
        int ones;
        m_rst = r;
        if (r) begin
            q.delete();
            m_loading = 0; m_err = 0; m_po0 = '0; m_po1 = '0;
        end else begin
            nl = 0; ne = 0;
            if (c) begin
                q.delete();
            end else if (v && !m_loading) begin
                q.push_back(s);
                if (q.size() == NB) begin
                    ones = 0;
                    foreach (q[i]) ones += int'(q[i]);
                    ok = (NB == N) ? 1'b1 : ((ones % 2) == 0);
                    if (ok) begin
                        for (int i = 0; i < N; i++) begin
                            m_po0[i]       = q[i];
                            m_po1[N-1-i]   = q[i];
                        end
                        nl = 1;
                    end else begin
                        ne = 1;
                    end
                    q.delete();
                end
            end
            m_loading = nl;
            m_err     = ne;
        end
    endtask

    task automatic chk_model();
        logic [7:0] exp0, exp1;
        bit mb;
        mb   = m_loading || (q.size() > 0);
        exp0 = {m_loading, mb, !m_rst && !m_loading, m_err, m_po0};
        exp1 = {m_loading, mb, !m_rst && !m_loading, m_err, m_po1};
        chk("model_lsb{load,busy,rdy,err,par_out}", 32'({load0, busy0, rdy0, err0, po0}), 32'(exp0));
        chk("model_msb{load,busy,rdy,err,par_out}", 32'({load1, busy1, rdy1, err1, po1}), 32'(exp1));
    endtask

    task automatic cyc(input bit r, input bit c, input bit v, input bit s);
        rst = r; clear = c; sin_valid = v; sin = s;
        @(posedge clk);
        model_step(r, c, v, s);
        #1;
        cycle++;
        chk_model();
    endtask

`ifndef PARITY_CHK_EN
    typedef struct {
        bit       r, c, v, s;
        bit       load, busy, rdy;
        bit [3:0] p0, p1;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input bit r, c, v, s, load, busy, rdy, input bit [3:0] p0, p1);
        vec_t e;
        e.r = r; e.c = c; e.v = v; e.s = s;
        e.load = load; e.busy = busy; e.rdy = rdy; e.p0 = p0; e.p1 = p1;
        tbl.push_back(e);
    endtask
`endif

    initial begin
`ifndef PARITY_CHK_EN
        //   rst clr v  s   load busy rdy  lsb   msb
        row(1, 0, 0, 0,   0, 0, 0,  4'h0, 4'h0);   // reset
        row(0, 0, 1, 1,   0, 1, 1,  4'h0, 4'h0);   // word 1101, consecutive
        row(0, 0, 1, 0,   0, 1, 1,  4'h0, 4'h0);
        row(0, 0, 1, 1,   0, 1, 1,  4'h0, 4'h0);
        row(0, 0, 1, 1,   1, 1, 0,  4'hD, 4'hB);
        row(0, 0, 0, 0,   0, 0, 1,  4'hD, 4'hB);
        row(0, 0, 1, 1,   0, 1, 1,  4'hD, 4'hB);   // same word, 2-cycle gap
        row(0, 0, 1, 0,   0, 1, 1,  4'hD, 4'hB);
        row(0, 0, 0, 0,   0, 1, 1,  4'hD, 4'hB);
        row(0, 0, 0, 0,   0, 1, 1,  4'hD, 4'hB);
        row(0, 0, 1, 1,   0, 1, 1,  4'hD, 4'hB);
        row(0, 0, 1, 1,   1, 1, 0,  4'hD, 4'hB);
        row(0, 0, 0, 0,   0, 0, 1,  4'hD, 4'hB);
        row(0, 0, 1, 1,   0, 1, 1,  4'hD, 4'hB);   // back-to-back 1101, 0110
        row(0, 0, 1, 0,   0, 1, 1,  4'hD, 4'hB);
        row(0, 0, 1, 1,   0, 1, 1,  4'hD, 4'hB);
        row(0, 0, 1, 1,   1, 1, 0,  4'hD, 4'hB);
        row(0, 0, 1, 0,   0, 0, 1,  4'hD, 4'hB);   // LOAD bubble: bit not taken
        row(0, 0, 1, 0,   0, 1, 1,  4'hD, 4'hB);
        row(0, 0, 1, 1,   0, 1, 1,  4'hD, 4'hB);
        row(0, 0, 1, 1,   0, 1, 1,  4'hD, 4'hB);
        row(0, 0, 1, 0,   1, 1, 0,  4'h6, 4'h6);
        row(0, 0, 0, 0,   0, 0, 1,  4'h6, 4'h6);
        row(0, 0, 1, 1,   0, 1, 1,  4'h6, 4'h6);   // two bits then clear
        row(0, 0, 1, 1,   0, 1, 1,  4'h6, 4'h6);
        row(0, 1, 1, 1,   0, 0, 1,  4'h6, 4'h6);
        row(0, 0, 1, 0,   0, 1, 1,  4'h6, 4'h6);   // 0,0,1,0
        row(0, 0, 1, 0,   0, 1, 1,  4'h6, 4'h6);
        row(0, 0, 1, 1,   0, 1, 1,  4'h6, 4'h6);
        row(0, 0, 1, 0,   1, 1, 0,  4'h4, 4'h2);
        row(0, 0, 0, 0,   0, 0, 1,  4'h4, 4'h2);
        row(0, 0, 1, 1,   0, 1, 1,  4'h4, 4'h2);   // rst after 3 bits
        row(0, 0, 1, 1,   0, 1, 1,  4'h4, 4'h2);
        row(0, 0, 1, 1,   0, 1, 1,  4'h4, 4'h2);
        row(1, 0, 0, 0,   0, 0, 0,  4'h0, 4'h0);
        row(0, 0, 0, 0,   0, 0, 1,  4'h0, 4'h0);
        row(0, 0, 1, 1,   0, 1, 1,  4'h0, 4'h0);   // 1,0,0,0 then clear in LOAD
        row(0, 0, 1, 0,   0, 1, 1,  4'h0, 4'h0);
        row(0, 0, 1, 0,   0, 1, 1,  4'h0, 4'h0);
        row(0, 0, 1, 0,   1, 1, 0,  4'h1, 4'h8);
        row(0, 1, 0, 0,   0, 0, 1,  4'h1, 4'h8);

        foreach (tbl[k]) begin
            cyc(tbl[k].r, tbl[k].c, tbl[k].v, tbl[k].s);
            chk($sformatf("row%0d_load", k),    32'(load0), 32'(tbl[k].load));
            chk($sformatf("row%0d_busy", k),    32'(busy0), 32'(tbl[k].busy));
            chk($sformatf("row%0d_ready", k),   32'(rdy0),  32'(tbl[k].rdy));
            chk($sformatf("row%0d_par_out", k), 32'(po0),   32'(tbl[k].p0));
            chk($sformatf("row%0d_msb_out", k), 32'(po1),   32'(tbl[k].p1));
            chk($sformatf("row%0d_par_err", k), 32'(err0),  32'h0);
        end
`else
        // Even parity: 1,0,1,1 + parity 1 is accepted.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 1); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1); cyc(0, 0, 1, 1);
        chk("par_wait_load", 32'(load0), 32'h0);
        chk("par_wait_out",  32'(po0),   32'h0);
        cyc(0, 0, 1, 1);
        chk("par_ok_load", 32'(load0), 32'h1);
        chk("par_ok_out",  32'(po0),   32'hD);
        cyc(0, 0, 0, 0);
        // Same data with parity 0 is rejected.
        cyc(0, 0, 1, 1); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1); cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
        chk("par_bad_err",  32'(err0),  32'h1);
        chk("par_bad_load", 32'(load0), 32'h0);
        chk("par_bad_out",  32'(po0),   32'hD);
        cyc(0, 0, 0, 0);
        chk("par_err_pulse", 32'(err0), 32'h0);
`endif

        // Random phase against the reference model.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 2000; k++) begin
            cyc($urandom_range(63) == 0, $urandom_range(15) == 0,
                $urandom_range(9) < 7, 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
